// File: rtl/stream_accumulator_pkg.sv
// rtl/stream_accumulator_pkg.sv - shared state encoding and defaults for stream_accumulator
package stream_accumulator_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } acc_state_e;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/stream_accumulator_ppa.sv
// rtl/stream_accumulator_ppa.sv - 32-bit Kogge-Stone parallel prefix adder (PPA_32)
module PPA_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  logic [31:0] p0;
  logic [31:0] gen;
  logic [31:0] prop;
  logic [31:0] gen_n;
  logic [31:0] prop_n;
  logic [31:0] carry;

  // Five doubling-span prefix levels; gen[i]/prop[i] end up covering bits [i:0].
  always_comb begin
    p0     = A ^ B;
    gen    = A & B;
    prop   = p0;
    gen_n  = gen;
    prop_n = prop;
    for (int lvl = 0; lvl < 5; lvl++) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << lvl)) begin
          gen_n[i]  = gen[i] | (prop[i] & gen[i - (1 << lvl)]);
          prop_n[i] = prop[i] & prop[i - (1 << lvl)];
        end else begin
          gen_n[i]  = gen[i];
          prop_n[i] = prop[i];
        end
      end
      gen  = gen_n;
      prop = prop_n;
    end
    carry = {gen[30:0] | (prop[30:0] & {31{Cin}}), Cin};
    S     = p0 ^ carry;
    Cout  = gen[31] | (prop[31] & Cin);
  end

endmodule

// File: rtl/stream_accumulator.sv
// rtl/stream_accumulator.sv - packetised add/subtract accumulator around PPA_32
module stream_accumulator
  import stream_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_uovf,
  output logic             out_sovf
);

  acc_state_e       state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             uovf_q;
  logic             sovf_q;

  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] count_d;
  logic             uovf_d;
  logic             sovf_d;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             beat_accept;
  logic             handoff;

  assign b_op = in_sub ? ~in_data : in_data;

  PPA_32 u_adder (
    .A    (acc_q),
    .B    (b_op),
    .Cin  (in_sub),
    .S    (sum),
    .Cout (cout)
  );

  assign beat_accept = in_valid && (state_q == ST_ACC);
  assign handoff     = out_ready && (state_q == ST_HOLD);

  // Subtraction is A + ~B + 1, so a missing carry-out there means a borrow.
  always_comb begin
    acc_d   = sum;
    count_d = (&count_q) ? count_q : count_q + 1'b1;
    uovf_d  = uovf_q | (in_sub ? ~cout : cout);
    sovf_d  = sovf_q | ((acc_q[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      count_q <= '0;
      uovf_q  <= 1'b0;
      sovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (beat_accept) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            uovf_q  <= uovf_d;
            sovf_q  <= sovf_d;
            if (in_last) begin
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (handoff) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
            uovf_q  <= 1'b0;
            sovf_q  <= 1'b0;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign out_uovf  = uovf_q;
  assign out_sovf  = sovf_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// tb/tb_stream_accumulator.sv - directed self-checking bench for stream_accumulator
module tb_stream_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_count;
  logic        out_uovf;
  logic        out_sovf;

  int n_checks = 0;
  int n_errors = 0;

  stream_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_uovf  (out_uovf),
    .out_sovf  (out_sovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic beat(input logic [31:0] d, input logic sub, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("beat_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the accepting edge of the last beat; checks and hands off.
  task automatic expect_result(input string tag, input logic [31:0] sum, input logic [7:0] cnt,
                               input logic uovf, input logic sovf);
    @(negedge clk);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_sum"},   out_sum, sum);
    check({tag, "_count"}, {24'b0, out_count}, {24'b0, cnt});
    check({tag, "_uovf"},  {31'b0, out_uovf}, {31'b0, uovf});
    check({tag, "_sovf"},  {31'b0, out_sovf}, {31'b0, sovf});
    check({tag, "_inrdy"}, {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_clr_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_clr_rdy"},   {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_sum",   out_sum, 32'd0);
    check("rst_count", {24'b0, out_count}, 32'd0);
    @(posedge clk);
    #1;

    // in_last without in_valid must be ignored
    in_last = 1'b1;
    in_data = 32'd77;
    repeat (2) @(posedge clk);
    #1;
    in_last = 1'b0;
    @(negedge clk);
    check("idle_last_valid", {31'b0, out_valid}, 32'd0);
    check("idle_last_sum", out_sum, 32'd0);
    @(posedge clk);
    #1;

    beat(32'd5, 1'b0, 1'b0);
    beat(32'd7, 1'b0, 1'b0);
    beat(32'd3, 1'b1, 1'b1);
    expect_result("basic", 32'd9, 8'd3, 1'b0, 1'b0);

    beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    beat(32'h0000_0002, 1'b0, 1'b1);
    expect_result("uwrap", 32'h0000_0001, 8'd2, 1'b1, 1'b0);

    beat(32'h7FFF_FFFF, 1'b0, 1'b0);
    beat(32'h0000_0001, 1'b0, 1'b1);
    expect_result("sovf", 32'h8000_0000, 8'd2, 1'b0, 1'b1);
    beat(32'd0, 1'b1, 1'b1);
    expect_result("flagclr", 32'd0, 8'd1, 1'b0, 1'b0);

    beat(32'd1, 1'b1, 1'b1);
    expect_result("borrow", 32'hFFFF_FFFF, 8'd1, 1'b1, 1'b0);

    // Backpressure: extra beat must wait out the HOLD period
    beat(32'd5, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd100;
    in_sub   = 1'b0;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_ready", {31'b0, in_ready}, 32'd0);
      check("hold_sum", out_sum, 32'd5);
      check("hold_count", {24'b0, out_count}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("hold_release_ready", {31'b0, in_ready}, 32'd1);
    check("hold_release_sum", out_sum, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("held_beat", 32'd100, 8'd1, 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      beat(32'd1, 1'b0, (k == 299));
    end
    expect_result("sat", 32'd300, 8'd255, 1'b0, 1'b0);

    beat(32'd10, 1'b0, 1'b0);
    beat(32'd20, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    beat(32'd4, 1'b0, 1'b1);
    expect_result("after_rst", 32'd4, 8'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
